shared_round_key_sequencer: RTL and testbench

- Control and buffering stage directly downstream of the two-share key expansion block.
- Drives the expansion enable and tracks the expansion's two-cycle-per-round rhythm.
- Captures each valid round-key share pair (round 0 = master key shares, rounds 1..NR = expanded keys) into a small share-preserving FIFO.
- Serves those keys to the masked encryption round datapath over a valid/ready handshake. Shares are never recombined.

---
 rtl/shared_round_key_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_shared_round_key_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_round_key_sequencer.sv
// Shared round-key sequencer: drives the two-share key expansion, captures
// each valid key share pair (round 0 = master key) into a small FIFO and
// serves them to the masked round datapath. Shares are never recombined.
//
// Handshake: rk_valid is high whenever the FIFO holds a key; the head
// (rk_out0/rk_out1/rk_idx) is consumed on a cycle where rk_valid and
// rk_ready are both high. rk_valid does not depend on rk_ready.
module shared_round_key_sequencer #(
   parameter int NR    = 16,
   parameter int KW    = 128,
   parameter int DEPTH = 2,
   parameter int IDXW  = 5
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            abort,
   input  logic [KW-1:0]   rk_in0,
   input  logic [KW-1:0]   rk_in1,
   output logic            key_exp_ena,
   output logic [KW-1:0]   rk_out0,
   output logic [KW-1:0]   rk_out1,
   output logic [IDXW-1:0] rk_idx,
   output logic            rk_valid,
   input  logic            rk_ready,
   output logic            busy,
   output logic            done,
   output logic            ovf_err,
   output logic [1:0]      dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [IDXW-1:0] LAST_RND = IDXW'(NR);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXPAND = 2'd2, FIN = 2'd3} state_t;

   state_t            state, state_nxt;
   logic              push, flush, start_ok;
   logic              phase;
   logic [IDXW-1:0]   rnd;
   logic [IDXW-1:0]   push_idx;

   logic [KW-1:0]     mem0 [DEPTH];
   logic [KW-1:0]     mem1 [DEPTH];
   logic [IDXW-1:0]   mem_idx [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr, rd_inc, fill;
   logic              full, empty, pop, push_ok;

   assign dbg_state = state;
   assign push_idx  = (state == LOAD) ? '0 : rnd;
   assign fill      = wr_ptr - rd_ptr;
   assign rd_inc    = rd_ptr + (AW+1)'(1);
   assign full      = (fill == (AW+1)'(DEPTH));
   assign empty     = (fill == '0);
   assign rk_valid  = !empty;
   // A flush in the same cycle discards everything, so it also cancels the pop.
   assign pop       = rk_valid && rk_ready && !flush;
   assign push_ok   = push && (!full || pop);

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode and per-state control outputs.
   always_comb begin
      state_nxt   = state;
      key_exp_ena = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      push        = 1'b0;
      flush       = 1'b0;
      start_ok    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = LOAD;
               flush     = 1'b1;
               start_ok  = 1'b1;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else begin
               push      = 1'b1;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            busy        = 1'b1;
            key_exp_ena = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               flush     = 1'b1;
            end else if (phase) begin
               push = 1'b1;
               if (rnd == LAST_RND) state_nxt = FIN;
            end
         end
         FIN: begin
            state_nxt = IDLE;
            if (abort) flush = 1'b1;
            else       done  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Expansion rhythm: odd phase of each round carries the valid key.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase <= 1'b0;
         rnd   <= '0;
      end else if (state == LOAD) begin
         phase <= 1'b0;
         rnd   <= IDXW'(1);
      end else if (state == EXPAND) begin
         phase <= ~phase;
         if (phase) rnd <= rnd + IDXW'(1);
      end
   end

   // Overflow flag: sticky until the next accepted start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                     ovf_err <= 1'b0;
      else if (start_ok)             ovf_err <= 1'b0;
      else if (push && full && !pop) ovf_err <= 1'b1;
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)     rd_ptr <= rd_inc;
      end
   end

   // FIFO storage, one register per share.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem0[wr_ptr[AW-1:0]]    <= rk_in0;
         mem1[wr_ptr[AW-1:0]]    <= rk_in1;
         mem_idx[wr_ptr[AW-1:0]] <= push_idx;
      end
   end

   // Registered head: reloads only on a push into an empty FIFO or on a pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rk_out0 <= '0;
         rk_out1 <= '0;
         rk_idx  <= '0;
      end else if (!flush) begin
         if (pop) begin
            if (fill > (AW+1)'(1)) begin
               rk_out0 <= mem0[rd_inc[AW-1:0]];
               rk_out1 <= mem1[rd_inc[AW-1:0]];
               rk_idx  <= mem_idx[rd_inc[AW-1:0]];
            end else if (push_ok) begin
               rk_out0 <= rk_in0;
               rk_out1 <= rk_in1;
               rk_idx  <= push_idx;
            end
         end else if (push_ok && empty) begin
            rk_out0 <= rk_in0;
            rk_out1 <= rk_in1;
            rk_idx  <= push_idx;
         end
      end
   end

endmodule

// File: tb/tb_shared_round_key_sequencer.sv
// Bench for shared_round_key_sequencer: a stand-in two-share key expansion
// feeds the DUT, and a queue-based model of the schedule and FIFO predicts
// every output cycle by cycle.
module tb_shared_round_key_sequencer;

   localparam int NR = 16, KW = 128, DEPTH = 2, IDXW = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic            start, abort, rk_ready;
   logic [KW-1:0]   rk_in0, rk_in1, rk_out0, rk_out1;
   logic            key_exp_ena, rk_valid, busy, done, ovf_err;
   logic [IDXW-1:0] rk_idx;
   logic [1:0]      dbg_state;

   shared_round_key_sequencer #(.NR(NR), .KW(KW), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .rk_in0(rk_in0), .rk_in1(rk_in1), .key_exp_ena(key_exp_ena),
      .rk_out0(rk_out0), .rk_out1(rk_out1), .rk_idx(rk_idx), .rk_valid(rk_valid),
      .rk_ready(rk_ready), .busy(busy), .done(done), .ovf_err(ovf_err),
      .dbg_state(dbg_state)
   );

   // ---------------- stand-in key expansion ----------------
   logic [KW-1:0] k0_arr [NR+1];
   logic [KW-1:0] k1_arr [NR+1];
   logic [KW-1:0] kref   [NR+1];
   int ena_cnt;
   int kidx;

   always @(posedge clk or negedge rstn) begin
      if (!rstn)            ena_cnt <= 0;
      else if (key_exp_ena) ena_cnt <= ena_cnt + 1;
      else                  ena_cnt <= 0;
   end

   // Enabled: key r appears on the second cycle of each two-cycle round.
   assign kidx   = key_exp_ena ? (((ena_cnt + 1) / 2 > NR) ? NR : (ena_cnt + 1) / 2) : 0;
   assign rk_in0 = k0_arr[kidx];
   assign rk_in1 = k1_arr[kidx];

   function automatic logic [KW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic gen_keys(input bit fixed);
      logic [KW-1:0] m;
      if (fixed) begin
         k0_arr[0] = 128'h0123456789abcdef0123456789abcdef;
         k1_arr[0] = 128'hfedcba9876543210fedcba9876543210;
      end else begin
         k0_arr[0] = rand128();
         k1_arr[0] = rand128();
      end
      kref[0] = k0_arr[0] ^ k1_arr[0];
      for (int r = 1; r <= NR; r++) begin
         kref[r]   = {kref[r-1][119:0], kref[r-1][127:120]} ^ {96'd0, 32'(r) * 32'h9e3779b9};
         m         = rand128();
         k0_arr[r] = kref[r] ^ m;
         k1_arr[r] = m;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [IDXW-1:0] exp_q[$];
   int  sc;        // -1 idle, 1 = LOAD cycle, 2..33 expansion, 34 = done cycle
   bit  m_ovf;
   int  n_assert, n_fail;
   int  n_hs, n_ena, n_done;

   task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      sc    = -1;
      m_ovf = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model.
   task automatic tick(input bit st, input bit ab, input bit rdy);
      bit sched;
      @(negedge clk);
      start = st; abort = ab; rk_ready = rdy;
      #1;
      sched = (sc >= 1 && sc <= 2*NR+1);
      chk("rk_valid", rk_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("rk_idx",  rk_idx,  exp_q[0]);
         chk("rk_out0", rk_out0, k0_arr[exp_q[0]]);
         chk("rk_out1", rk_out1, k1_arr[exp_q[0]]);
         chk("rk_key",  rk_out0 ^ rk_out1, kref[exp_q[0]]);
      end
      chk("key_exp_ena", key_exp_ena, sc >= 2 && sc <= 2*NR+1);
      chk("busy", busy, sched);
      chk("done", done, sc == 2*NR+2 && !ab);
      chk("ovf_err", ovf_err, m_ovf);
      if (key_exp_ena) n_ena++;
      if (done) n_done++;
      if (st && !ab && sc < 0) begin
         exp_q.delete();
         m_ovf = 1'b0;
         sc    = 1;
      end else if (ab && sc >= 1) begin
         exp_q.delete();
         sc = -1;
      end else begin
         if (rdy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_hs++;
         end
         if (sched && (sc % 2 == 1)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(IDXW'((sc - 1) / 2));
            else m_ovf = 1'b1;
         end
         if (sched) sc = sc + 1;
         else if (sc == 2*NR+2) sc = -1;
      end
      @(posedge clk);
   endtask

   task automatic clr_counts();
      n_hs = 0; n_ena = 0; n_done = 0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_assert = 0; n_fail = 0;
      clr_counts();
      model_reset();
      start = 0; abort = 0; rk_ready = 0;
      gen_keys(1'b1);
      rstn = 1'b0;
      #12;
      chk("rst_state", dbg_state, 2'd0);
      chk("rst_ena", key_exp_ena, 1'b0);
      chk("rst_valid", rk_valid, 1'b0);
      chk("rst_out0", rk_out0, '0);
      chk("rst_out1", rk_out1, '0);
      chk("rst_idx", rk_idx, '0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovf", ovf_err, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) tick(0, 0, 1);

      // Full schedule with the fixed master key and a ready consumer.
      clr_counts();
      tick(1, 0, 1);
      repeat (2*NR + 6) tick(0, 0, 1);
      chk("t1_handshakes", n_hs, NR + 1);
      chk("t1_ena_cycles", n_ena, 2*NR);
      chk("t1_done_pulses", n_done, 1);

      // No consumer for the whole schedule: two keys kept, then overflow.
      gen_keys(1'b0);
      clr_counts();
      tick(1, 0, 0);
      repeat (2*NR + 6) tick(0, 0, 0);
      chk("t2_ovf_sticky", ovf_err, 1'b1);
      repeat (4) tick(0, 0, 1);
      chk("t2_handshakes", n_hs, 2);

      // Consumer toggling: production matches consumption, no overflow.
      gen_keys(1'b0);
      clr_counts();
      tick(1, 0, 1);
      repeat (2*NR + 6) tick(0, 0, sc % 2 == 0);
      chk("t3_ovf", ovf_err, 1'b0);
      chk("t3_handshakes", n_hs, NR + 1);

      // Abort ten cycles after start, then a clean rerun.
      gen_keys(1'b0);
      clr_counts();
      tick(1, 0, 1);
      repeat (9) tick(0, 0, 1);
      tick(0, 1, 1);
      repeat (2*NR) tick(0, 0, 1);
      chk("t4_no_done", n_done, 0);
      clr_counts();
      tick(1, 0, 1);
      repeat (2*NR + 6) tick(0, 0, 1);
      chk("t4_rerun_hs", n_hs, NR + 1);

      // Start pulsed again during a run is ignored.
      gen_keys(1'b0);
      clr_counts();
      tick(1, 0, 1);
      repeat (4) tick(0, 0, 1);
      tick(1, 0, 1);
      repeat (2*NR + 4) tick(0, 0, 1);
      chk("t5_done_pulses", n_done, 1);
      chk("t5_handshakes", n_hs, NR + 1);

      // Start together with abort in IDLE: stays idle.
      tick(1, 1, 1);
      #1;
      chk("t6_state", dbg_state, 2'd0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_ena", key_exp_ena, 1'b0);
      repeat (2) tick(0, 0, 1);

      // Random consumer behaviour over several schedules.
      for (int run = 0; run < 3; run++) begin
         gen_keys(1'b0);
         tick(1, 0, $urandom_range(0, 1));
         repeat (2*NR + 4) tick(0, 0, $urandom_range(0, 1));
         repeat (4) tick(0, 0, 1);
      end

      // Asynchronous reset in the middle of a schedule.
      gen_keys(1'b0);
      tick(1, 0, 0);
      repeat (12) tick(0, 0, 0);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      chk("arst_state", dbg_state, 2'd0);
      chk("arst_ena", key_exp_ena, 1'b0);
      chk("arst_valid", rk_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_out0", rk_out0, '0);
      chk("arst_out1", rk_out1, '0);
      chk("arst_idx", rk_idx, '0);
      chk("arst_ovf", ovf_err, 1'b0);
      #1 rstn = 1'b1;
      repeat (3) tick(0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
